decode_issue_latch: RTL and testbench



---
 rtl/decode_issue_latch_if.sv | 48 ++++
 rtl/decode_issue_latch.sv | 140 ++++++++++++++
 tb/tb_decode_issue_latch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_latch_if.sv
// Fetch-buffer / decode-side bundle of the 3-slot decode issue latch.
// The latch takes the slave modport; the buffer/decode environment takes master.
interface decode_issue_latch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush_i;
  logic [2:0]            fetch_count_i;
  logic [2:0]            fetch_ready_o;
  logic [DATA_WIDTH-1:0] instruction_i_0, instruction_i_1, instruction_i_2;
  logic [DATA_WIDTH-1:0] pc_i_0, pc_i_1, pc_i_2;
  logic [DATA_WIDTH-1:0] imm_i_0, imm_i_1, imm_i_2;
  logic                  branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2;
  logic [DATA_WIDTH-1:0] pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2;
  logic [1:0]            issue_accept_i;
  logic [2:0]            issue_valid_o;
  logic [DATA_WIDTH-1:0] instruction_o_0, instruction_o_1, instruction_o_2;
  logic [DATA_WIDTH-1:0] pc_o_0, pc_o_1, pc_o_2;
  logic [DATA_WIDTH-1:0] imm_o_0, imm_o_1, imm_o_2;
  logic                  branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
  logic [DATA_WIDTH-1:0] pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2;
  logic [1:0]            occupancy_o;

  modport master (
    output flush_i, fetch_count_i, issue_accept_i,
    output instruction_i_0, instruction_i_1, instruction_i_2,
    output pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2,
    output branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2,
    output pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2,
    input  fetch_ready_o, issue_valid_o, occupancy_o,
    input  instruction_o_0, instruction_o_1, instruction_o_2,
    input  pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2,
    input  branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2,
    input  pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2
  );

  modport slave (
    input  flush_i, fetch_count_i, issue_accept_i,
    input  instruction_i_0, instruction_i_1, instruction_i_2,
    input  pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2,
    input  branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2,
    input  pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2,
    output fetch_ready_o, issue_valid_o, occupancy_o,
    output instruction_o_0, instruction_o_1, instruction_o_2,
    output pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2,
    output branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2,
    output pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2
  );
endinterface

// File: rtl/decode_issue_latch.sv
// 3-slot in-order latch between the instruction buffer and the decoders.
// Optional perf counters: define DECODE_ISSUE_PERF_CNT_EN.
module decode_issue_latch #(
  parameter int DATA_WIDTH = 32,
  parameter int SLOTS      = 3
) (
  input  logic        clk,
  input  logic        reset,
`ifdef DECODE_ISSUE_PERF_CNT_EN
  output logic [31:0] starve_cnt_o,
  output logic [31:0] backpressure_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  decode_issue_latch_if.slave bus
);

  if (SLOTS != 3) begin : g_slots_check
    $error("decode_issue_latch only supports SLOTS == 3");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pred_pc;
    logic                  taken;
  } slot_t;

  slot_t      slot_q [SLOTS];
  slot_t      slot_d [SLOTS];
  slot_t      in_slot [SLOTS];
  logic [1:0] occ_q, occ_d;
  logic [2:0] valid_q, valid_d;
  logic [1:0] fetch_clamped, free, acc, rem, nin;

  always_comb begin
    in_slot[0] = '{bus.instruction_i_0, bus.pc_i_0, bus.imm_i_0, bus.pc_at_prediction_i_0,
                   bus.branch_prediction_i_0};
    in_slot[1] = '{bus.instruction_i_1, bus.pc_i_1, bus.imm_i_1, bus.pc_at_prediction_i_1,
                   bus.branch_prediction_i_1};
    in_slot[2] = '{bus.instruction_i_2, bus.pc_i_2, bus.imm_i_2, bus.pc_at_prediction_i_2,
                   bus.branch_prediction_i_2};
  end

  // Intake is bounded by the registered free count, never by this cycle's drain,
  // so decode back-pressure cannot reach the buffer pop combinationally.
  always_comb begin
    fetch_clamped = (bus.fetch_count_i > 3'd3) ? 2'd3 : bus.fetch_count_i[1:0];
    free          = 2'd3 - occ_q;
    acc           = (bus.issue_accept_i > occ_q) ? occ_q : bus.issue_accept_i;
    rem           = occ_q - acc;
    nin           = (fetch_clamped > free) ? free : fetch_clamped;
    occ_d         = bus.flush_i ? 2'd0 : 2'(rem + nin);
  end

  always_comb begin
    case (occ_d)
      2'd0:    valid_d = 3'b000;
      2'd1:    valid_d = 3'b001;
      2'd2:    valid_d = 3'b011;
      default: valid_d = 3'b111;
    endcase
  end

  // Survivors shift down by acc, newcomers land right behind them.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      slot_d[k] = slot_q[k];
      if (k < int'(rem)) begin
        slot_d[k] = slot_q[k + int'(acc)];
      end else if ((k - int'(rem)) < int'(nin)) begin
        slot_d[k] = in_slot[k - int'(rem)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= 2'd0;
      valid_q <= 3'b000;
      for (int k = 0; k < SLOTS; k++) slot_q[k] <= '0;
    end else begin
      occ_q   <= occ_d;
      valid_q <= valid_d;
      if (!bus.flush_i) begin
        for (int k = 0; k < SLOTS; k++) slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    case (occ_q)
      2'd0:    bus.fetch_ready_o = 3'b111;
      2'd1:    bus.fetch_ready_o = 3'b011;
      2'd2:    bus.fetch_ready_o = 3'b001;
      default: bus.fetch_ready_o = 3'b000;
    endcase
  end

  assign bus.issue_valid_o         = valid_q;
  assign bus.occupancy_o           = occ_q;
  assign bus.instruction_o_0       = slot_q[0].instr;
  assign bus.instruction_o_1       = slot_q[1].instr;
  assign bus.instruction_o_2       = slot_q[2].instr;
  assign bus.pc_o_0                = slot_q[0].pc;
  assign bus.pc_o_1                = slot_q[1].pc;
  assign bus.pc_o_2                = slot_q[2].pc;
  assign bus.imm_o_0               = slot_q[0].imm;
  assign bus.imm_o_1               = slot_q[1].imm;
  assign bus.imm_o_2               = slot_q[2].imm;
  assign bus.pc_at_prediction_o_0  = slot_q[0].pred_pc;
  assign bus.pc_at_prediction_o_1  = slot_q[1].pred_pc;
  assign bus.pc_at_prediction_o_2  = slot_q[2].pred_pc;
  assign bus.branch_prediction_o_0 = slot_q[0].taken;
  assign bus.branch_prediction_o_1 = slot_q[1].taken;
  assign bus.branch_prediction_o_2 = slot_q[2].taken;

`ifdef DECODE_ISSUE_PERF_CNT_EN
  logic [31:0] starve_q, backpressure_q, flush_q;

  // Saturating event counters; flush does not clear them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q       <= '0;
      backpressure_q <= '0;
      flush_q        <= '0;
    end else begin
      if (occ_q == 2'd0 && !bus.flush_i && starve_q != '1) starve_q <= starve_q + 32'd1;
      if (bus.fetch_count_i > {1'b0, free} && backpressure_q != '1)
        backpressure_q <= backpressure_q + 32'd1;
      if (bus.flush_i && flush_q != '1) flush_q <= flush_q + 32'd1;
    end
  end

  assign starve_cnt_o       = starve_q;
  assign backpressure_cnt_o = backpressure_q;
  assign flush_cnt_o        = flush_q;
`endif

endmodule

// File: tb/tb_decode_issue_latch.sv
// Self-checking bench for decode_issue_latch: directed steps then random traffic,
// compared against a queue-based model of the latch contents.
module tb_decode_issue_latch;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pcp;
    logic        bp;
  } entry_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  int     assertCount = 0;
  int     failCount = 0;
  entry_t model[$];
  entry_t inEnt[3];
  entry_t saved[3];

  decode_issue_latch_if #(.DATA_WIDTH(32)) bus ();

`ifdef DECODE_ISSUE_PERF_CNT_EN
  logic [31:0] starveCnt, backpressureCnt, flushCnt;
`endif

  decode_issue_latch #(.DATA_WIDTH(32), .SLOTS(3)) dut (
    .clk               (clk),
    .reset             (reset),
`ifdef DECODE_ISSUE_PERF_CNT_EN
    .starve_cnt_o      (starveCnt),
    .backpressure_cnt_o(backpressureCnt),
    .flush_cnt_o       (flushCnt),
`endif
    .bus               (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic entry_t dutSlot(input int k);
    entry_t e;
    case (k)
      0: e = '{bus.instruction_o_0, bus.pc_o_0, bus.imm_o_0, bus.pc_at_prediction_o_0,
               bus.branch_prediction_o_0};
      1: e = '{bus.instruction_o_1, bus.pc_o_1, bus.imm_o_1, bus.pc_at_prediction_o_1,
               bus.branch_prediction_o_1};
      default: e = '{bus.instruction_o_2, bus.pc_o_2, bus.imm_o_2, bus.pc_at_prediction_o_2,
                     bus.branch_prediction_o_2};
    endcase
    return e;
  endfunction

  function automatic entry_t makeEntry(input logic [31:0] pc);
    entry_t e;
    e.instr = $urandom;
    e.pc    = pc;
    e.imm   = $urandom;
    e.pcp   = $urandom;
    e.bp    = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // Occupancy/ready/valid derive from the model size; every held slot must match in order.
  task automatic checkOutput(input string step);
    int     s;
    entry_t d;
    s = model.size();
    checkEq({step, "_occupancy"}, 32'(bus.occupancy_o), 32'(s));
    checkEq({step, "_issue_valid"}, 32'(bus.issue_valid_o), 32'((1 << s) - 1));
    checkEq({step, "_fetch_ready"}, 32'(bus.fetch_ready_o), 32'((1 << (3 - s)) - 1));
    for (int k = 0; k < s; k++) begin
      d = dutSlot(k);
      checkEq($sformatf("%s_slot%0d_instr", step, k), d.instr, model[k].instr);
      checkEq($sformatf("%s_slot%0d_pc", step, k), d.pc, model[k].pc);
      checkEq($sformatf("%s_slot%0d_imm", step, k), d.imm, model[k].imm);
      checkEq($sformatf("%s_slot%0d_pcp", step, k), d.pcp, model[k].pcp);
      checkEq($sformatf("%s_slot%0d_bp", step, k), 32'(d.bp), 32'(model[k].bp));
    end
  endtask

  // Drives one cycle, advances the model at the edge, checks 1 time unit later.
  task automatic applyStimulus(input string step, input int count, input int accept,
                               input bit flush);
    int sz, a, c, n;
    bus.fetch_count_i         = 3'(count);
    bus.issue_accept_i        = 2'(accept);
    bus.flush_i               = flush;
    bus.instruction_i_0       = inEnt[0].instr;
    bus.instruction_i_1       = inEnt[1].instr;
    bus.instruction_i_2       = inEnt[2].instr;
    bus.pc_i_0                = inEnt[0].pc;
    bus.pc_i_1                = inEnt[1].pc;
    bus.pc_i_2                = inEnt[2].pc;
    bus.imm_i_0               = inEnt[0].imm;
    bus.imm_i_1               = inEnt[1].imm;
    bus.imm_i_2               = inEnt[2].imm;
    bus.pc_at_prediction_i_0  = inEnt[0].pcp;
    bus.pc_at_prediction_i_1  = inEnt[1].pcp;
    bus.pc_at_prediction_i_2  = inEnt[2].pcp;
    bus.branch_prediction_i_0 = inEnt[0].bp;
    bus.branch_prediction_i_1 = inEnt[1].bp;
    bus.branch_prediction_i_2 = inEnt[2].bp;
    @(posedge clk);
    if (flush) begin
      model.delete();
    end else begin
      sz = model.size();
      a  = (accept > sz) ? sz : accept;
      c  = (count > 3) ? 3 : count;
      n  = (c > 3 - sz) ? 3 - sz : c;
      repeat (a) void'(model.pop_front());
      for (int j = 0; j < n; j++) model.push_back(inEnt[j]);
    end
    #1;
    checkOutput(step);
  endtask

  task automatic loadInputs(input logic [31:0] pc0, input logic [31:0] pc1,
                            input logic [31:0] pc2);
    inEnt[0] = makeEntry(pc0);
    inEnt[1] = makeEntry(pc1);
    inEnt[2] = makeEntry(pc2);
  endtask

  initial begin
    entry_t d;
    loadInputs(32'h0, 32'h0, 32'h0);
    applyStimulus("idle_in_reset", 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("after_reset");

    // Empty latch filled with three instructions.
    loadInputs(32'h100, 32'h104, 32'h108);
    applyStimulus("fill3", 3, 0, 1'b0);
    checkEq("fill3_pc0", bus.pc_o_0, 32'h100);
    checkEq("fill3_pc2", bus.pc_o_2, 32'h108);
    checkEq("fill3_ready", 32'(bus.fetch_ready_o), 32'h0);

    // Full latch drains one and accepts none.
    loadInputs(32'h300, 32'h304, 32'h308);
    applyStimulus("full_drain1", 3, 1, 1'b0);
    checkEq("full_drain1_occ", 32'(bus.occupancy_o), 32'd2);
    checkEq("full_drain1_pc0", bus.pc_o_0, 32'h104);
    checkEq("full_drain1_pc1", bus.pc_o_1, 32'h108);

    // Reach occ=1 holding 0x200, then drain one while filling two.
    loadInputs(32'h200, 32'h3f0, 32'h3f4);
    applyStimulus("to_occ1", 1, 2, 1'b0);
    loadInputs(32'h204, 32'h208, 32'h3f8);
    saved[0] = inEnt[0];
    saved[1] = inEnt[1];
    applyStimulus("drain_fill", 2, 1, 1'b0);
    checkEq("drain_fill_occ", 32'(bus.occupancy_o), 32'd2);
    checkEq("drain_fill_pc0", bus.pc_o_0, 32'h204);
    checkEq("drain_fill_pc1", bus.pc_o_1, 32'h208);
    checkEq("drain_fill_bp1", 32'(bus.branch_prediction_o_1), 32'(saved[1].bp));
    checkEq("drain_fill_pcp0", bus.pc_at_prediction_o_0, saved[0].pcp);

    // Flush discards incoming entries and ignores accept.
    checkEq("pre_flush_ready", 32'(bus.fetch_ready_o), 32'b001);
    loadInputs(32'h400, 32'h404, 32'h408);
    applyStimulus("flush", 3, 2, 1'b1);
    checkEq("flush_occ", 32'(bus.occupancy_o), 32'd0);
    checkEq("flush_ready", 32'(bus.fetch_ready_o), 32'b111);

    // Over-accept and over-count are both clamped.
    loadInputs(32'h500, 32'h504, 32'h508);
    applyStimulus("to_occ1b", 1, 0, 1'b0);
    loadInputs(32'h600, 32'h604, 32'h608);
    applyStimulus("over_accept", 6, 3, 1'b0);
    checkEq("over_accept_occ", 32'(bus.occupancy_o), 32'd2);
    checkEq("over_accept_pc0", bus.pc_o_0, 32'h600);

    // Empty latch with nothing offered holds.
    applyStimulus("drain_all", 0, 3, 1'b0);
    applyStimulus("empty_hold", 0, 0, 1'b0);

    // Asynchronous reset mid-cycle while occ=2.
    loadInputs(32'h700, 32'h704, 32'h708);
    applyStimulus("pre_reset", 2, 0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    model.delete();
    checkOutput("async_reset");
    for (int k = 0; k < 3; k++) begin
      d = dutSlot(k);
      checkEq($sformatf("reset_slot%0d_instr", k), d.instr, 32'h0);
      checkEq($sformatf("reset_slot%0d_pc", k), d.pc, 32'h0);
      checkEq($sformatf("reset_slot%0d_imm", k), d.imm, 32'h0);
      checkEq($sformatf("reset_slot%0d_pcp", k), d.pcp, 32'h0);
      checkEq($sformatf("reset_slot%0d_bp", k), 32'(d.bp), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;

    // Random traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      loadInputs($urandom, $urandom, $urandom);
      applyStimulus("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
